speed_ramp_gen: RTL and testbench
=================================

Name: speed_ramp_gen

Overview:
- Upstream stage of the 20-bit pulse maker: drives its 8-bit speed command and speed-set handshake.
- Moves the commanded speed from its current value to a latched target in fixed increments, one increment per ramp interval, so the stepper accelerates and decelerates without step loss.
- One instance per motor channel; the CPU bus writes the target and the stop request.

Parameters:
- TICK_DIV, 16'd1000: Clk cycles per ramp interval; legal range 8..65535.
- STEP, 8'd1: speed increment or decrement applied per interval; legal range 1..255.
- HS_TIMEOUT, 8'd32: handshake watchdog limit in Clk cycles; used only with the optional feature.

Ports:
- Clk  in  1  system clock.
- gRst  in  1  reset; asynchronous, active-high.
- TargetSpeed  in  8  new target speed, sampled when TargetLoad=1.
- TargetLoad  in  1  one-cycle strobe that latches TargetSpeed into TgtReg.
- Stop  in  1  level or strobe that forces TgtReg to 0 (controlled deceleration).
- SpeedSetDone  in  1  handshake return from the pulse maker (SpeedSet delayed by 2 Clk).
- SpeedCmd  out  8  speed command to the pulse maker; registered.
- SpeedSet  out  1  request that the pulse maker latch SpeedCmd; registered.
- Busy  out  1  1 while a ramp is in progress or a handshake is in flight.
- AtSpeed  out  1  1 when CurSpeed==TgtReg and no handshake is in flight.

Behaviour:
- Reset (async, gRst=1): TgtReg=0, CurSpeed=0, SpeedCmd=0, SpeedSet=0, Busy=0, AtSpeed=1, tick counter=0, state=IDLE. Reset aborts any in-flight handshake immediately.
- Target latch: Stop=1 sets TgtReg=0 on that edge and has priority over TargetLoad in the same cycle. Otherwise TargetLoad=1 sets TgtReg=TargetSpeed. The target may change in any state; the new value is used at the next step computation.
- SpeedCmd always equals CurSpeed. It changes only on entry to SET_HI and is held stable until the FSM leaves SET_LO.
- FSM states:
  - IDLE: tick counter=0. If CurSpeed!=TgtReg, go to DWELL.
  - DWELL: tick counter increments each Clk. When it reaches TICK_DIV-1, compute the next speed:
    - if TgtReg>CurSpeed: next = min(CurSpeed+STEP, TgtReg)
    - if TgtReg<CurSpeed: next = max(CurSpeed-STEP, TgtReg)
    - compute at 9-bit width: no wrap past 255 or below 0, never overshoot the target.
    - Load CurSpeed=next, go to SET_HI.
    - If TgtReg==CurSpeed at tick time (target was changed), go to IDLE and issue no handshake.
  - SET_HI: SpeedSet=1. When SpeedSetDone==1 is sampled, go to SET_LO.
  - SET_LO: SpeedSet=0. When SpeedSetDone==0 is sampled, go to DWELL with the tick counter cleared if CurSpeed!=TgtReg, else go to IDLE.
- Handshake timing with a 2-cycle pulse maker: SpeedSet high for 3 Clk; about 6 Clk from SET_HI entry to DWELL. Step period = TICK_DIV + handshake cycles.
- First step after leaving IDLE occurs TICK_DIV cycles after DWELL entry.
- Busy = (state!=IDLE). AtSpeed = (state==IDLE) && (CurSpeed==TgtReg). Both are registered.
- A speed of 0 is a legal command; the final decel step issues SpeedCmd=0 with a full handshake.

Optional Feature:
- Macro RAMP_HS_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counts Clk cycles spent in SET_HI or SET_LO.
  - On reaching HS_TIMEOUT: SpeedSet=0, state=IDLE, CurSpeed keeps its last issued value, and sticky output HsErr (1 bit, reset 0) is set.
  - HsErr clears on gRst or on TargetLoad.
  - While HsErr=1 the FSM stays in IDLE.
- Undefined: no watchdog, no HsErr port, and the FSM waits in SET_HI/SET_LO indefinitely.

Test Plan:
- All tests use TICK_DIV=8, STEP=4, and a pulse-maker model with SpeedSetDone = SpeedSet delayed 2 Clk.
- Reset mid-handshake: assert gRst while SpeedSet=1 -> same edge gives SpeedCmd=0, SpeedSet=0, Busy=0, AtSpeed=1; FSM in IDLE after release.
- Accel 0->20: TargetLoad with 20 -> SpeedCmd sequence 4,8,12,16,20, one SpeedSet pulse (3 Clk high) each; first pulse 8 Clk after DWELL entry; AtSpeed=1 after the last SpeedSetDone falls.
- Saturation: from 0, target 10 -> sequence 4,8,10. Target 254 from 252 with STEP=4 -> 254, no wrap.
- Stop priority: at speed 20, pulse Stop and TargetLoad(200) in the same cycle -> TgtReg=0; sequence 16,12,8,4,0.
- Retarget in flight: load target 8 while in SET_HI issuing 12 during an accel to 20 -> SpeedCmd holds 12 until Done falls, then steps to 8.
- RAMP_HS_TIMEOUT_EN: tie SpeedSetDone=0 -> after 32 Clk in SET_HI: HsErr=1, SpeedSet=0, Busy=0; TargetLoad clears HsErr.

Source files
------------

// File: rtl/speed_ramp_gen.sv
`default_nettype none
// ============================================================================
// speed_ramp_gen : ramps SpeedCmd toward a latched target by STEP every
//                  TICK_DIV clocks, one SpeedSet/SpeedSetDone handshake per step.
// Optional macro RAMP_HS_TIMEOUT_EN adds a handshake watchdog and HsErr.
// Revision: 1.0
// ============================================================================
module speed_ramp_gen #(
    parameter logic [15:0] TICK_DIV   = 16'd1000,
    parameter logic [7:0]  STEP       = 8'd1,
    parameter logic [7:0]  HS_TIMEOUT = 8'd32
) (
    input  logic       Clk,
    input  logic       gRst,
    input  logic [7:0] TargetSpeed,
    input  logic       TargetLoad,
    input  logic       Stop,
    input  logic       SpeedSetDone,
    output logic [7:0] SpeedCmd,
    output logic       SpeedSet,
    output logic       Busy,
`ifdef RAMP_HS_TIMEOUT_EN
    output logic       AtSpeed,
    output logic       HsErr
`else
    output logic       AtSpeed
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DWELL  = 2'd1,
        S_SET_HI = 2'd2,
        S_SET_LO = 2'd3
    } state_t;

    state_t      state;
    logic [7:0]  tgt_reg;
    logic [7:0]  cur_speed;
    logic [15:0] tick_cnt;
    logic [7:0]  tgt_next;
    logic [7:0]  step_speed;
    logic [8:0]  up_sum;
    logic [8:0]  dn_diff;
    logic        hs_timeout;
    logic        hs_block;

    assign SpeedCmd = cur_speed;

    always_comb begin
        tgt_next = tgt_reg;
        if (Stop) begin
            tgt_next = 8'd0;
        end else if (TargetLoad) begin
            tgt_next = TargetSpeed;
        end
    end

    // 9-bit arithmetic so neither direction wraps; clamp to target on overshoot
    always_comb begin
        up_sum     = {1'b0, cur_speed} + {1'b0, STEP};
        dn_diff    = {1'b0, cur_speed} - {1'b0, STEP};
        step_speed = tgt_reg;
        if (tgt_reg > cur_speed) begin
            if (up_sum < {1'b0, tgt_reg}) begin
                step_speed = up_sum[7:0];
            end
        end else if (tgt_reg < cur_speed) begin
            if (!dn_diff[8] && (dn_diff[7:0] > tgt_reg)) begin
                step_speed = dn_diff[7:0];
            end
        end
    end

`ifdef RAMP_HS_TIMEOUT_EN
    logic [7:0] wd_cnt;

    assign hs_block   = HsErr;
    assign hs_timeout = ((state == S_SET_HI) || (state == S_SET_LO)) &&
                        (wd_cnt == HS_TIMEOUT - 8'd1);

    always_ff @(posedge Clk or posedge gRst) begin
        if (gRst) begin
            wd_cnt <= 8'd0;
            HsErr  <= 1'b0;
        end else begin
            if (hs_timeout) begin
                HsErr <= 1'b1;
            end else if (TargetLoad) begin
                HsErr <= 1'b0;
            end
            if ((state == S_SET_HI) || (state == S_SET_LO)) begin
                wd_cnt <= wd_cnt + 8'd1;
            end else begin
                wd_cnt <= 8'd0;
            end
        end
    end
`else
    logic [7:0] unused_hs_timeout;
    assign unused_hs_timeout = HS_TIMEOUT;
    assign hs_block          = 1'b0;
    assign hs_timeout        = 1'b0;
`endif

    // Busy/AtSpeed are loaded with the values matching the next state and target
    always_ff @(posedge Clk or posedge gRst) begin
        if (gRst) begin
            state     <= S_IDLE;
            tgt_reg   <= 8'd0;
            cur_speed <= 8'd0;
            SpeedSet  <= 1'b0;
            Busy      <= 1'b0;
            AtSpeed   <= 1'b1;
            tick_cnt  <= 16'd0;
        end else begin
            tgt_reg <= tgt_next;
            if (hs_timeout) begin
                state    <= S_IDLE;
                SpeedSet <= 1'b0;
                Busy     <= 1'b0;
                AtSpeed  <= (cur_speed == tgt_next);
                tick_cnt <= 16'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        tick_cnt <= 16'd0;
                        if ((cur_speed != tgt_reg) && !hs_block) begin
                            state   <= S_DWELL;
                            Busy    <= 1'b1;
                            AtSpeed <= 1'b0;
                        end else begin
                            Busy    <= 1'b0;
                            AtSpeed <= (cur_speed == tgt_next);
                        end
                    end
                    S_DWELL: begin
                        if (tick_cnt == TICK_DIV - 16'd1) begin
                            tick_cnt <= 16'd0;
                            if (cur_speed != tgt_reg) begin
                                cur_speed <= step_speed;
                                SpeedSet  <= 1'b1;
                                state     <= S_SET_HI;
                            end else begin
                                state   <= S_IDLE;
                                Busy    <= 1'b0;
                                AtSpeed <= (cur_speed == tgt_next);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 16'd1;
                        end
                    end
                    S_SET_HI: begin
                        if (SpeedSetDone) begin
                            SpeedSet <= 1'b0;
                            state    <= S_SET_LO;
                        end
                    end
                    S_SET_LO: begin
                        if (!SpeedSetDone) begin
                            tick_cnt <= 16'd0;
                            if (cur_speed != tgt_reg) begin
                                state <= S_DWELL;
                            end else begin
                                state   <= S_IDLE;
                                Busy    <= 1'b0;
                                AtSpeed <= (cur_speed == tgt_next);
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_speed_ramp_gen.sv
`default_nettype none
// ============================================================================
// tb_speed_ramp_gen : vector table, corner sequences and randomized ramps
//                     for speed_ramp_gen (TICK_DIV=8, STEP=4).
// Revision: 1.0
// ============================================================================
module tb_speed_ramp_gen;

    localparam int STEP_I = 4;

    logic       Clk = 1'b0;
    logic       gRst = 1'b1;
    logic [7:0] TargetSpeed = 8'd0;
    logic       TargetLoad = 1'b0;
    logic       Stop = 1'b0;
    logic       SpeedSetDone;
    logic [7:0] SpeedCmd;
    logic       SpeedSet;
    logic       Busy;
    logic       AtSpeed;
`ifdef RAMP_HS_TIMEOUT_EN
    logic       HsErr;
`endif

    logic       pm_d1, pm_d2;
    logic       hold_done_low = 1'b0;

    int checks = 0;
    int errors = 0;
    int cur_model = 0;
    logic [7:0] mq[$];

    typedef struct {
        logic [7:0] tgt;
        bit         stop;
        int         n;
        int         first;
        int         last;
    } vec_t;
    vec_t vecs[11];

    speed_ramp_gen #(
        .TICK_DIV   (16'd8),
        .STEP       (8'd4),
        .HS_TIMEOUT (8'd32)
    ) dut (
        .Clk          (Clk),
        .gRst         (gRst),
        .TargetSpeed  (TargetSpeed),
        .TargetLoad   (TargetLoad),
        .Stop         (Stop),
        .SpeedSetDone (SpeedSetDone),
        .SpeedCmd     (SpeedCmd),
        .SpeedSet     (SpeedSet),
        .Busy         (Busy),
`ifdef RAMP_HS_TIMEOUT_EN
        .AtSpeed      (AtSpeed),
        .HsErr        (HsErr)
`else
        .AtSpeed      (AtSpeed)
`endif
    );

    always #5 Clk = ~Clk;

    // Pulse maker: SpeedSetDone is SpeedSet delayed by two clocks
    always @(posedge Clk or posedge gRst) begin
        if (gRst) begin
            pm_d1 <= 1'b0;
            pm_d2 <= 1'b0;
        end else begin
            pm_d1 <= SpeedSet;
            pm_d2 <= pm_d1;
        end
    end
    assign SpeedSetDone = hold_done_low ? 1'b0 : pm_d2;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] v, input bit st);
        TargetSpeed = v;
        TargetLoad  = 1'b1;
        Stop        = st;
        @(negedge Clk);
        TargetLoad  = 1'b0;
        Stop        = 1'b0;
    endtask

    // Watch until settled; collect issued speeds and count timing anomalies
    task automatic monitor(output int n, output int first, output int last,
                           output int bad, output bit to);
        int   hi, last_rise, busy_rise;
        logic prev_set, prev_busy, in_pulse;
        logic [7:0] held;
        mq.delete();
        n = 0; bad = 0; to = 1'b1;
        first = SpeedCmd; last = SpeedCmd; held = SpeedCmd;
        prev_set = SpeedSet; prev_busy = Busy; in_pulse = 1'b0;
        hi = 0; last_rise = -1; busy_rise = -1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (Busy && !prev_busy) busy_rise = cyc;
            if (SpeedSet && !prev_set) begin
                if (n == 0) first = SpeedCmd;
                if (n == 0 && busy_rise >= 0 && (cyc - busy_rise) != 8) bad++;
                if (last_rise >= 0 && (cyc - last_rise) != 14) bad++;
                mq.push_back(SpeedCmd);
                n++;
                last = SpeedCmd; held = SpeedCmd;
                last_rise = cyc; in_pulse = 1'b1; hi = 0;
            end else if (SpeedCmd != held) begin
                bad++;
            end
            if (SpeedSet) hi++;
            else if (prev_set && in_pulse) begin
                if (hi != 3) bad++;
                in_pulse = 1'b0;
            end
            prev_set = SpeedSet; prev_busy = Busy;
            if (AtSpeed && !Busy && !SpeedSet) begin
                to = 1'b0;
                break;
            end
            @(negedge Clk);
        end
    endtask

    task automatic run_ramp(input logic [7:0] v, input bit st,
                            output int n, output int first, output int last);
        int bad;
        bit to;
        load(v, st);
        monitor(n, first, last, bad, to);
        chk("settle_timeout", int'(to), 0);
        chk("handshake_timing", bad, 0);
    endtask

    initial begin
        int n, f, l, bad, k, m, t, cnt;
        bit to, ok, st;
        logic [7:0] v;

        vecs[0]  = '{8'd20,  1'b0, 5,  4,   20};
        vecs[1]  = '{8'd200, 1'b1, 5,  16,  0};
        vecs[2]  = '{8'd10,  1'b0, 3,  4,   10};
        vecs[3]  = '{8'd10,  1'b0, 0,  10,  10};
        vecs[4]  = '{8'd200, 1'b1, 3,  6,   0};
        vecs[5]  = '{8'd3,   1'b0, 1,  3,   3};
        vecs[6]  = '{8'd255, 1'b0, 63, 7,   255};
        vecs[7]  = '{8'd254, 1'b0, 1,  254, 254};
        vecs[8]  = '{8'd252, 1'b0, 1,  252, 252};
        vecs[9]  = '{8'd254, 1'b0, 1,  254, 254};
        vecs[10] = '{8'd0,   1'b0, 64, 250, 0};

        repeat (3) @(negedge Clk);
        chk("rst_cmd", int'(SpeedCmd), 0);
        chk("rst_set", int'(SpeedSet), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_atspeed", int'(AtSpeed), 1);
        gRst = 1'b0;
        repeat (2) @(negedge Clk);
        chk("idle_busy", int'(Busy), 0);
        chk("idle_atspeed", int'(AtSpeed), 1);

        for (int i = 0; i < 11; i++) begin
            run_ramp(vecs[i].tgt, vecs[i].stop, n, f, l);
            chk($sformatf("vec%0d_count", i), n, vecs[i].n);
            if (vecs[i].n > 0) begin
                chk($sformatf("vec%0d_first", i), f, vecs[i].first);
                chk($sformatf("vec%0d_last", i), l, vecs[i].last);
            end
            chk($sformatf("vec%0d_cmd", i), int'(SpeedCmd), vecs[i].last);
        end
        cur_model = 0;

        // Reset in the middle of a handshake
        load(8'd20, 1'b0);
        k = 0;
        while (!SpeedSet && k < 40) begin
            @(negedge Clk);
            k++;
        end
        chk("rsths_reached_set", int'(SpeedSet), 1);
        #2 gRst = 1'b1;
        #1;
        chk("rsths_cmd", int'(SpeedCmd), 0);
        chk("rsths_set", int'(SpeedSet), 0);
        chk("rsths_busy", int'(Busy), 0);
        chk("rsths_atspeed", int'(AtSpeed), 1);
        @(negedge Clk);
        gRst = 1'b0;
        repeat (12) @(negedge Clk);
        chk("rsths_idle_busy", int'(Busy), 0);
        chk("rsths_idle_set", int'(SpeedSet), 0);
        chk("rsths_idle_atspeed", int'(AtSpeed), 1);

        // Retarget while the 12 handshake is in flight
        load(8'd20, 1'b0);
        k = 0;
        while (!(SpeedSet && SpeedCmd == 8'd12) && k < 200) begin
            @(negedge Clk);
            k++;
        end
        chk("retgt_reached_12", int'(SpeedCmd), 12);
        load(8'd8, 1'b0);
        monitor(n, f, l, bad, to);
        chk("retgt_timeout", int'(to), 0);
        chk("retgt_hold_12", bad, 0);
        chk("retgt_count", n, 1);
        chk("retgt_value", f, 8);
        cur_model = 8;

        // Randomized ramps against an arithmetic model of the issued sequence
        for (int r = 0; r < 16; r++) begin
            st = ($urandom_range(0, 5) == 0);
            v  = 8'($urandom_range(0, 255));
            run_ramp(v, st, n, f, l);
            t = st ? 0 : int'(v);
            m = cur_model; k = 0; ok = 1'b1;
            while (m != t) begin
                if (t > m) m = (m + STEP_I >= t) ? t : m + STEP_I;
                else       m = (m - STEP_I <= t) ? t : m - STEP_I;
                if (k >= mq.size() || int'(mq[k]) != m) ok = 1'b0;
                k++;
            end
            if (k != mq.size()) ok = 1'b0;
            chk($sformatf("rand%0d_seq_from%0d_to%0d", r, cur_model, t), int'(ok), 1);
            chk($sformatf("rand%0d_cmd", r), int'(SpeedCmd), t);
            cur_model = t;
        end

`ifdef RAMP_HS_TIMEOUT_EN
        run_ramp(8'd0, 1'b0, n, f, l);
        hold_done_low = 1'b1;
        load(8'd20, 1'b0);
        k = 0;
        while (!SpeedSet && k < 40) begin
            @(negedge Clk);
            k++;
        end
        cnt = 0;
        while (SpeedSet && cnt < 100) begin
            @(negedge Clk);
            cnt++;
        end
        chk("hs_high_cycles", cnt, 32);
        chk("hs_err_set", int'(HsErr), 1);
        chk("hs_busy", int'(Busy), 0);
        chk("hs_cmd_kept", int'(SpeedCmd), 4);
        hold_done_low = 1'b0;
        repeat (4) @(negedge Clk);
        chk("hs_stays_idle", int'(Busy), 0);
        load(8'd20, 1'b0);
        chk("hs_err_cleared", int'(HsErr), 0);
        monitor(n, f, l, bad, to);
        chk("hs_resume_timeout", int'(to), 0);
        chk("hs_resume_cmd", int'(SpeedCmd), 20);
`else
        cnt = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
